ring_pattern_checker: RTL and testbench

RING_PATTERN_CHECKER -- requirements
Module: ring_pattern_checker

---
 rtl/ring_pattern_checker.sv | 237 +++++++++++++++++++++++
 tb/tb_ring_pattern_checker.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ring_pattern_checker.sv
// ---------------------------------------------------------------------------
// ring_pattern_checker
//
// Watches the state of an upstream left-rotating ring register and confirms
// that it rotates by exactly one position on every qualified clock edge.
// After a seed sample plus LOCK_N consecutive correct rotations the checker
// declares lock, then tracks the rotation phase and counts whole revolutions.
// Any wrong rotation while locked (including a stuck all-zeros/all-ones
// pattern) raises a one-cycle mismatch pulse and a sticky error flag, and
// drops the checker back to re-acquisition.
//
// Ports
//   clk        in   rising-edge clock shared with the ring register
//   reset      in   asynchronous, active-low reset
//   q_in       in   [WIDTH-1:0] ring register state
//   sample_en  in   1 = evaluate q_in on this edge, 0 = hold everything
//   clear_err  in   synchronous clear of err_sticky
//   locked     out  1 while in the LOCKED state
//   phase      out  [2:0] rotation position since lock, 0..WIDTH-1
//   rev_count  out  [7:0] completed revolutions while locked, saturating
//   mismatch   out  one-cycle pulse on a rotation error while locked
//   err_sticky out  set by mismatch, held until clear_err
//   static_pat out  last sample was all-zeros or all-ones
//
// Every output comes straight from a flop: the effect of a sampled q_in is
// visible one clock edge later.
// ---------------------------------------------------------------------------
module ring_pattern_checker #(
  parameter int WIDTH  = 6,
  parameter int LOCK_N = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q_in,
  input  logic             sample_en,
  input  logic             clear_err,
  output logic             locked,
  output logic [2:0]       phase,
  output logic [7:0]       rev_count,
  output logic             mismatch,
  output logic             err_sticky,
  output logic             static_pat
);

  // good_cnt must be able to hold the value LOCK_N itself.
  localparam int CNT_W = $clog2(LOCK_N + 1);

  localparam logic [CNT_W-1:0] LOCK_TARGET = CNT_W'(LOCK_N);
  localparam logic [2:0]       PHASE_LAST  = 3'(WIDTH - 1);
  localparam logic [7:0]       REV_MAX     = 8'hFF;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  // Expected next ring value: one-bit left rotation.
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x);
    return {x[WIDTH-2:0], x[WIDTH-1]};
  endfunction

  // A ring stuck at all-zeros or all-ones rotates onto itself, so it would
  // otherwise look like a valid rotation; it is never accepted as a match.
  function automatic logic is_static(input logic [WIDTH-1:0] x);
    return (x == {WIDTH{1'b0}}) || (x == {WIDTH{1'b1}});
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] prev_nxt_s;
  logic [CNT_W-1:0] good_cnt_r;
  logic [CNT_W-1:0] good_cnt_nxt_s;
  logic [CNT_W-1:0] good_inc_s;
  logic [2:0]       phase_r;
  logic [2:0]       phase_nxt_s;
  logic [7:0]       rev_r;
  logic [7:0]       rev_nxt_s;
  logic             locked_r;
  logic             locked_nxt_s;
  logic             mismatch_r;
  logic             mismatch_nxt_s;
  logic             err_r;
  logic             err_nxt_s;
  logic             static_r;
  logic             static_nxt_s;
  logic             q_static_s;
  logic             match_s;
  logic             lock_hit_s;

  assign q_static_s = is_static(q_in);
  assign match_s    = sample_en && (q_in == rotl(prev_r)) && !q_static_s;
  assign good_inc_s = good_cnt_r + CNT_W'(1);
  // This match completes the run of LOCK_N good rotations.
  assign lock_hit_s = (good_inc_s == LOCK_TARGET);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_UNLOCKED;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; only qualified edges move the FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_UNLOCKED: begin
        if (sample_en) begin
          state_nxt_s = ST_ACQUIRE;
        end else begin
          state_nxt_s = ST_UNLOCKED;
        end
      end
      ST_ACQUIRE: begin
        if (match_s && lock_hit_s) begin
          state_nxt_s = ST_LOCKED;
        end else begin
          state_nxt_s = ST_ACQUIRE;
        end
      end
      ST_LOCKED: begin
        if (!sample_en) begin
          state_nxt_s = ST_LOCKED;
        end else if (match_s) begin
          state_nxt_s = ST_LOCKED;
        end else begin
          state_nxt_s = ST_ACQUIRE;
        end
      end
      // An unreachable encoding restarts acquisition from scratch.
      default: state_nxt_s = ST_UNLOCKED;
    endcase
  end

  // Output/datapath next values; registered below so every output is a flop.
  always_comb begin
    prev_nxt_s     = prev_r;
    good_cnt_nxt_s = good_cnt_r;
    phase_nxt_s    = phase_r;
    rev_nxt_s      = rev_r;
    mismatch_nxt_s = 1'b0;
    static_nxt_s   = static_r;
    // clear_err is an independent control; a mismatch below overrides it.
    if (clear_err) begin
      err_nxt_s = 1'b0;
    end else begin
      err_nxt_s = err_r;
    end

    if (sample_en) begin
      prev_nxt_s   = q_in;
      static_nxt_s = q_static_s;
      case (state_r)
        ST_UNLOCKED: begin
          // First sample only seeds prev.
          good_cnt_nxt_s = {CNT_W{1'b0}};
          phase_nxt_s    = 3'd0;
        end
        ST_ACQUIRE: begin
          if (match_s && lock_hit_s) begin
            good_cnt_nxt_s = {CNT_W{1'b0}};
            phase_nxt_s    = 3'd0;
          end else if (match_s) begin
            good_cnt_nxt_s = good_inc_s;
          end else begin
            // A break in the run restarts counting; no error is flagged
            // because lock has not been claimed yet.
            good_cnt_nxt_s = {CNT_W{1'b0}};
          end
        end
        ST_LOCKED: begin
          if (match_s) begin
            if (phase_r == PHASE_LAST) begin
              phase_nxt_s = 3'd0;
              if (rev_r != REV_MAX) begin
                rev_nxt_s = rev_r + 8'd1;
              end else begin
                rev_nxt_s = rev_r;
              end
            end else begin
              phase_nxt_s = phase_r + 3'd1;
            end
          end else begin
            // Lost lock: the revolution count is deliberately kept.
            mismatch_nxt_s = 1'b1;
            err_nxt_s      = 1'b1;
            good_cnt_nxt_s = {CNT_W{1'b0}};
            phase_nxt_s    = 3'd0;
          end
        end
        default: begin
          good_cnt_nxt_s = {CNT_W{1'b0}};
          phase_nxt_s    = 3'd0;
        end
      endcase
    end else begin
      prev_nxt_s = prev_r;
    end

    locked_nxt_s = (state_nxt_s == ST_LOCKED);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_r     <= {WIDTH{1'b0}};
      good_cnt_r <= {CNT_W{1'b0}};
      phase_r    <= 3'd0;
      rev_r      <= 8'd0;
      locked_r   <= 1'b0;
      mismatch_r <= 1'b0;
      err_r      <= 1'b0;
      static_r   <= 1'b0;
    end else begin
      prev_r     <= prev_nxt_s;
      good_cnt_r <= good_cnt_nxt_s;
      phase_r    <= phase_nxt_s;
      rev_r      <= rev_nxt_s;
      locked_r   <= locked_nxt_s;
      mismatch_r <= mismatch_nxt_s;
      err_r      <= err_nxt_s;
      static_r   <= static_nxt_s;
    end
  end

  assign locked     = locked_r;
  assign phase      = phase_r;
  assign rev_count  = rev_r;
  assign mismatch   = mismatch_r;
  assign err_sticky = err_r;
  assign static_pat = static_r;

endmodule

// File: tb/tb_ring_pattern_checker.sv
// ---------------------------------------------------------------------------
// tb_ring_pattern_checker
//
// Table-driven bench for ring_pattern_checker. Each stimulus step pushes its
// expected outputs onto a scoreboard queue; after the clock edge the entry is
// popped and compared with the DUT outputs. Long and timing-sensitive cases
// (saturating revolution count, asynchronous reset, relock) are hand-written.
// ---------------------------------------------------------------------------
module tb_ring_pattern_checker;

  logic       clk;
  logic       reset;
  logic [5:0] q_in;
  logic       sample_en;
  logic       clear_err;
  logic       locked;
  logic [2:0] phase;
  logic [7:0] rev_count;
  logic       mismatch;
  logic       err_sticky;
  logic       static_pat;

  ring_pattern_checker #(.WIDTH(6), .LOCK_N(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .q_in       (q_in),
    .sample_en  (sample_en),
    .clear_err  (clear_err),
    .locked     (locked),
    .phase      (phase),
    .rev_count  (rev_count),
    .mismatch   (mismatch),
    .err_sticky (err_sticky),
    .static_pat (static_pat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       lk;
    logic [2:0] ph;
    logic [7:0] rc;
    logic       mm;
    logic       err;
    logic       st;
  } exp_t;

  typedef struct packed {
    logic [5:0] q;
    logic       en;
    logic       clr;
    exp_t       e;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t mk(input logic lk, input logic [2:0] ph,
                              input logic [7:0] rc, input logic mm,
                              input logic err, input logic st);
    exp_t e;
    e.lk = lk; e.ph = ph; e.rc = rc; e.mm = mm; e.err = err; e.st = st;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [5:0] q, input logic en,
                               input logic clr, input exp_t e);
    vec_t v;
    v.q = q; v.en = en; v.clr = clr; v.e = e;
    return v;
  endfunction

  // Pop the oldest expectation and compare it against the live outputs.
  task automatic compare(input string name);
    exp_t e;
    exp_t act;
    n_checks++;
    act = mk(locked, phase, rev_count, mismatch, err_sticky, static_pat);
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, no expected value", name);
    end else begin
      e = sb_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got lk=%0b ph=%0d rc=%0d mm=%0b err=%0b st=%0b, expected lk=%0b ph=%0d rc=%0d mm=%0b err=%0b st=%0b",
                 name, act.lk, act.ph, act.rc, act.mm, act.err, act.st,
                 e.lk, e.ph, e.rc, e.mm, e.err, e.st);
      end
    end
  endtask

  // Drive one step on the falling edge, clock it, check on the next falling edge.
  task automatic step(input logic [5:0] q, input logic en, input logic clr,
                      input exp_t e, input string name);
    q_in      = q;
    sample_en = en;
    clear_err = clr;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    compare(name);
  endtask

  initial begin
    logic [5:0] one_hot;
    logic [7:0] rc_exp;
    int         rc_int;

    // --- vector table -----------------------------------------------------
    // acquire: seed + 5 rotations -> lock on 6th sample
    tbl.push_back(mkv(6'b000001, 1'b1, 1'b0, mk(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b000010, 1'b1, 1'b0, mk(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b000100, 1'b1, 1'b0, mk(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b001000, 1'b1, 1'b0, mk(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b010000, 1'b1, 1'b0, mk(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b100000, 1'b1, 1'b0, mk(1'b1, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0)));
    // one revolution while locked
    tbl.push_back(mkv(6'b000001, 1'b1, 1'b0, mk(1'b1, 3'd1, 8'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b000010, 1'b1, 1'b0, mk(1'b1, 3'd2, 8'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b000100, 1'b1, 1'b0, mk(1'b1, 3'd3, 8'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b001000, 1'b1, 1'b0, mk(1'b1, 3'd4, 8'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b010000, 1'b1, 1'b0, mk(1'b1, 3'd5, 8'd0, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b100000, 1'b1, 1'b0, mk(1'b1, 3'd0, 8'd1, 1'b0, 1'b0, 1'b0)));
    // sample_en low: garbage on q_in is ignored, everything holds
    tbl.push_back(mkv(6'b000011, 1'b0, 1'b0, mk(1'b1, 3'd0, 8'd1, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b111111, 1'b0, 1'b0, mk(1'b1, 3'd0, 8'd1, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b000000, 1'b0, 1'b0, mk(1'b1, 3'd0, 8'd1, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b000001, 1'b1, 1'b0, mk(1'b1, 3'd1, 8'd1, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b000010, 1'b1, 1'b0, mk(1'b1, 3'd2, 8'd1, 1'b0, 1'b0, 1'b0)));
    // wrong rotation while locked
    tbl.push_back(mkv(6'b000011, 1'b1, 1'b0, mk(1'b0, 3'd0, 8'd1, 1'b1, 1'b1, 1'b0)));
    tbl.push_back(mkv(6'b000110, 1'b1, 1'b0, mk(1'b0, 3'd0, 8'd1, 1'b0, 1'b1, 1'b0)));
    tbl.push_back(mkv(6'b001100, 1'b1, 1'b1, mk(1'b0, 3'd0, 8'd1, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b011000, 1'b1, 1'b0, mk(1'b0, 3'd0, 8'd1, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b110000, 1'b1, 1'b0, mk(1'b0, 3'd0, 8'd1, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b100001, 1'b1, 1'b0, mk(1'b1, 3'd0, 8'd1, 1'b0, 1'b0, 1'b0)));
    // static pattern while locked, with clear_err at the same time
    tbl.push_back(mkv(6'b111111, 1'b1, 1'b1, mk(1'b0, 3'd0, 8'd1, 1'b1, 1'b1, 1'b1)));
    for (int i = 0; i < 5; i++) begin
      tbl.push_back(mkv(6'b111111, 1'b1, 1'b0, mk(1'b0, 3'd0, 8'd1, 1'b0, 1'b1, 1'b1)));
    end
    tbl.push_back(mkv(6'b000000, 1'b1, 1'b0, mk(1'b0, 3'd0, 8'd1, 1'b0, 1'b1, 1'b1)));
    tbl.push_back(mkv(6'b000001, 1'b1, 1'b1, mk(1'b0, 3'd0, 8'd1, 1'b0, 1'b0, 1'b0)));
    // relock from prev=000001
    tbl.push_back(mkv(6'b000010, 1'b1, 1'b0, mk(1'b0, 3'd0, 8'd1, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b000100, 1'b1, 1'b0, mk(1'b0, 3'd0, 8'd1, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b001000, 1'b1, 1'b0, mk(1'b0, 3'd0, 8'd1, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b010000, 1'b1, 1'b0, mk(1'b0, 3'd0, 8'd1, 1'b0, 1'b0, 1'b0)));
    tbl.push_back(mkv(6'b100000, 1'b1, 1'b0, mk(1'b1, 3'd0, 8'd1, 1'b0, 1'b0, 1'b0)));

    // --- reset state ------------------------------------------------------
    reset     = 1'b0;
    q_in      = 6'b000000;
    sample_en = 1'b0;
    clear_err = 1'b0;
    #1;
    sb_q.push_back(mk(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0));
    compare("reset_state");
    @(negedge clk);
    reset = 1'b1;

    // --- table ------------------------------------------------------------
    foreach (tbl[i]) begin
      step(tbl[i].q, tbl[i].en, tbl[i].clr, tbl[i].e, $sformatf("vec%0d", i));
    end

    // --- 300 revolutions while locked: rev_count saturates at 255 ---------
    for (int i = 0; i < 1800; i++) begin
      one_hot = 6'b000001 << (i % 6);
      rc_int  = 1 + (i + 1) / 6;
      if (rc_int > 255) begin
        rc_exp = 8'd255;
      end else begin
        rc_exp = 8'(rc_int);
      end
      step(one_hot, 1'b1, 1'b0, mk(1'b1, 3'((i + 1) % 6), rc_exp, 1'b0, 1'b0, 1'b0), "rev_run");
    end

    // --- partway into a revolution, then asynchronous reset ---------------
    step(6'b000001, 1'b1, 1'b0, mk(1'b1, 3'd1, 8'd255, 1'b0, 1'b0, 1'b0), "mid_rev1");
    step(6'b000010, 1'b1, 1'b0, mk(1'b1, 3'd2, 8'd255, 1'b0, 1'b0, 1'b0), "mid_rev2");
    step(6'b000100, 1'b1, 1'b0, mk(1'b1, 3'd3, 8'd255, 1'b0, 1'b0, 1'b0), "mid_rev3");
    sample_en = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    sb_q.push_back(mk(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0));
    compare("async_reset");
    #1;
    reset = 1'b1;
    @(negedge clk);

    // --- after reset a new seed plus LOCK_N matches is needed -------------
    step(6'b000010, 1'b1, 1'b0, mk(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0), "reseed");
    step(6'b000100, 1'b1, 1'b0, mk(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0), "reacq1");
    step(6'b001000, 1'b1, 1'b0, mk(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0), "reacq2");
    step(6'b010000, 1'b1, 1'b0, mk(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0), "reacq3");
    step(6'b100000, 1'b1, 1'b0, mk(1'b0, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0), "reacq4");
    step(6'b000001, 1'b1, 1'b0, mk(1'b1, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0), "relock");

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
